// File: rtl/conv_pad_stream.sv
// Streaming border padder: turns a W x H raster into a (W+2*PAD) x (H+2*PAD) raster
// by inserting a latched fill value around the edge, one pixel per cycle, no frame storage.
`timescale 1ns/1ps
module conv_pad_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int W          = 220,
    parameter int H          = 220,
    parameter int PAD        = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pad_val,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int WO = W + 2 * PAD;
    localparam int HO = H + 2 * PAD;
    localparam int CW = $clog2(WO + 1);
    localparam int RW = $clog2(HO + 1);

    localparam logic [CW-1:0] C_LO   = CW'(PAD);
    localparam logic [CW-1:0] C_W    = CW'(W);
    localparam logic [CW-1:0] C_LAST = CW'(WO - 1);
    localparam logic [RW-1:0] R_LO   = RW'(PAD);
    localparam logic [RW-1:0] R_H    = RW'(H);
    localparam logic [RW-1:0] R_LAST = RW'(HO - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_c;
    logic [RW-1:0]         r_r;
    logic [DATA_WIDTH-1:0] r_pad_val;
    logic                  r_done;

    logic w_ld;
    logic w_interior;
    logic w_last;
    logic w_adv;
    logic [CW-1:0] w_c_off;
    logic [RW-1:0] w_r_off;

    // Offsetting by PAD wraps positions left/above the interior to large values,
    // so a single unsigned compare covers both edges of each axis.
    assign w_c_off    = r_c - C_LO;
    assign w_r_off    = r_r - R_LO;
    assign w_interior = (w_c_off < C_W) && (w_r_off < R_H);
    assign w_last     = (r_c == C_LAST) && (r_r == R_LAST);
    assign w_ld       = !out_valid || out_ready;

    assign in_ready = (r_state == S_RUN) && w_interior && w_ld;
    assign w_adv    = (r_state == S_RUN) && w_ld && (!w_interior || in_valid);
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_c       <= '0;
            r_r       <= '0;
            r_pad_val <= '0;
            r_done    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is deliberately dropped.
                    if (start && !r_done) begin
                        r_pad_val <= pad_val;
                        r_c       <= '0;
                        r_r       <= '0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_adv) begin
                        out_valid <= 1'b1;
                        out_data  <= w_interior ? in_data : r_pad_val;
                        out_sof   <= (r_c == '0) && (r_r == '0);
                        out_eol   <= (r_c == C_LAST);
                        out_eof   <= w_last;
                        if (w_last) begin
                            r_c     <= '0;
                            r_r     <= '0;
                            r_state <= S_FLUSH;
                        end else if (r_c == C_LAST) begin
                            r_c <= '0;
                            r_r <= r_r + 1'b1;
                        end else begin
                            r_c <= r_c + 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pad_stream.sv
// Scoreboard bench for conv_pad_stream: a 4x3/PAD=1 instance and a 2x2/PAD=0 instance.
`timescale 1ns/1ps
module tb_conv_pad_stream;

    typedef struct packed {
        logic [31:0] d;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pad_val = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_sof, out_eol, out_eof;
    logic        out_ready = 1'b1;
    logic        busy, done;

    logic        s_start = 1'b0;
    logic [31:0] s_pad_val = 32'hFFFF_FFFF;
    logic        s_in_valid = 1'b0;
    logic [31:0] s_in_data = '0;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic        s_out_sof, s_out_eol, s_out_eof;
    logic        s_out_ready = 1'b1;
    logic        s_busy, s_done;

    exp_t q[$];
    exp_t q2[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   pop_cnt = 0;
    int   in_hs = 0;
    logic toggle_rdy = 1'b0;

    always #5 clk = ~clk;

    conv_pad_stream #(.DATA_WIDTH(32), .W(4), .H(3), .PAD(1)) dut (
        .clk(clk), .reset(reset), .start(start), .pad_val(pad_val),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    conv_pad_stream #(.DATA_WIDTH(32), .W(2), .H(2), .PAD(0)) dut0 (
        .clk(clk), .reset(reset), .start(s_start), .pad_val(s_pad_val),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_sof(s_out_sof),
        .out_eol(s_out_eol), .out_eof(s_out_eof), .out_ready(s_out_ready),
        .busy(s_busy), .done(s_done)
    );

    // Monitor for the padded instance: data/markers, stall stability, done timing, input count.
    logic prev_stall = 1'b0;
    exp_t held;
    logic done_exp = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            done_exp   = 1'b0;
        end else begin
            if (prev_stall) begin
                n_vec++;
                if (!out_valid || {out_data, out_sof, out_eol, out_eof} !== held) begin
                    n_err++;
                    $display("FAIL stall_stable: got v=%0b %h required v=1 %h", out_valid,
                             {out_data, out_sof, out_eol, out_eof}, held);
                end
            end
            prev_stall = out_valid && !out_ready;
            held       = {out_data, out_sof, out_eol, out_eof};
            if (done || done_exp) begin
                n_vec++;
                if (done !== done_exp) begin
                    n_err++;
                    $display("FAIL done_pulse: got %0b required %0b", done, done_exp);
                end
            end
            done_exp = out_valid && out_ready && out_eof;
            if (out_valid && out_ready) begin
                n_vec++;
                pop_cnt++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got %h required none", out_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if ({out_data, out_sof, out_eol, out_eof} !== e) begin
                        n_err++;
                        $display("FAIL pixel: got d=%h sof=%0b eol=%0b eof=%0b required d=%h sof=%0b eol=%0b eof=%0b",
                                 out_data, out_sof, out_eol, out_eof, e.d, e.sof, e.eol, e.eof);
                    end
                end
            end
            if (in_valid && in_ready) in_hs++;
        end
    end

    always @(negedge clk) begin
        if (!reset && s_out_valid && s_out_ready) begin
            n_vec++;
            if (q2.size() == 0) begin
                n_err++;
                $display("FAIL pad0_unexpected: got %h required none", s_out_data);
            end else begin
                exp_t e;
                e = q2.pop_front();
                if ({s_out_data, s_out_sof, s_out_eol, s_out_eof} !== e) begin
                    n_err++;
                    $display("FAIL pad0_pixel: got d=%h sof=%0b eol=%0b eof=%0b required d=%h sof=%0b eol=%0b eof=%0b",
                             s_out_data, s_out_sof, s_out_eol, s_out_eof, e.d, e.sof, e.eol, e.eof);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        out_ready = toggle_rdy ? ~out_ready : 1'b1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Expected 6x5 output: border = pv, interior = 1..12 in raster order.
    task automatic push_frame(input logic [31:0] pv);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 6; c++) begin
                exp_t e;
                e.d   = (r >= 1 && r <= 3 && c >= 1 && c <= 4) ? 32'((r - 1) * 4 + c) : pv;
                e.sof = (r == 0 && c == 0);
                e.eol = (c == 5);
                e.eof = (c == 5 && r == 4);
                q.push_back(e);
            end
        end
    endtask

    task automatic feed(input int i);
        int  t;
        logic hs;
        in_valid = 1'b1;
        in_data  = 32'(i);
        t  = 0;
        hs = 1'b0;
        while (!hs && t < 200) begin
            @(negedge clk);
            hs = in_ready;
            tick();
            t++;
        end
        if (!hs) begin
            n_err++;
            $display("FAIL input_timeout: pixel %0d got no handshake required one", i);
        end
    endtask

    task automatic run_frame(input logic [31:0] pv, input int stall_at, input bit bad_start);
        int hs0, pop0, t;
        push_frame(pv);
        hs0  = in_hs;
        pop0 = pop_cnt;
        pad_val = pv;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        pad_val = ~pv;
        for (int i = 1; i <= 12; i++) begin
            if (i == stall_at) begin
                in_valid = 1'b0;
                repeat (5) tick();
                chk("stall_position", 64'(pop_cnt - pop0), 64'd14);
            end
            feed(i);
            if (i == 7 && bad_start) begin
                in_valid = 1'b0;
                start    = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        in_valid = 1'b1;
        in_data  = 32'hBAD0_BAD0;
        t = 0;
        while (!done && t < 300) begin
            tick();
            t++;
        end
        if (!done) begin
            n_err++;
            $display("FAIL done_timeout: got no done required done");
        end
        start   = 1'b1;
        pad_val = 32'h5555_5555;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("start_on_done_ignored", 64'(busy), 64'd0);
        chk("input_handshakes", 64'(in_hs - hs0), 64'd12);
        chk("output_count", 64'(pop_cnt - pop0), 64'd30);
        chk("queue_drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_markers", 64'({out_sof, out_eol, out_eof}), 64'd0);
        chk("rst_in_ready_busy_done", 64'({in_ready, busy, done}), 64'd0);
        reset = 1'b0;
        tick();

        run_frame(32'h0000_0000, 0, 1'b0);
        toggle_rdy = 1'b1;
        run_frame(32'hDEAD_BEEF, 0, 1'b1);
        toggle_rdy = 1'b0;
        tick();
        run_frame(32'h1234_5678, 6, 1'b0);

        // Abort mid-row 2 with an asynchronous reset, then run a clean frame.
        push_frame(32'hCAFE_F00D);
        pad_val = 32'hCAFE_F00D;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 6; i++) feed(i);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_data_markers", 64'({out_data, out_sof, out_eol, out_eof}), 64'd0);
        chk("abort_in_ready_busy_done", 64'({in_ready, busy, done}), 64'd0);
        q.delete();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("abort_no_done", 64'(done), 64'd0);
        run_frame(32'hCAFE_F00D, 0, 1'b0);

        // PAD=0 pass-through.
        begin
            int t;
            q2.push_back({32'h0000_00A1, 1'b1, 1'b0, 1'b0});
            q2.push_back({32'h0000_00A2, 1'b0, 1'b1, 1'b0});
            q2.push_back({32'h0000_00A3, 1'b0, 1'b0, 1'b0});
            q2.push_back({32'h0000_00A4, 1'b0, 1'b1, 1'b1});
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
            for (int i = 1; i <= 4; i++) begin
                logic hs;
                s_in_valid = 1'b1;
                s_in_data  = 32'h0000_00A0 + 32'(i);
                hs = 1'b0;
                t  = 0;
                while (!hs && t < 100) begin
                    @(negedge clk);
                    hs = s_in_ready;
                    tick();
                    t++;
                end
                if (!hs) begin
                    n_err++;
                    $display("FAIL pad0_input_timeout: pixel %0d got no handshake required one", i);
                end
            end
            s_in_valid = 1'b0;
            t = 0;
            while (!s_done && t < 50) begin
                tick();
                t++;
            end
            chk("pad0_done", 64'(s_done), 64'd1);
            chk("pad0_queue_drained", 64'(q2.size()), 64'd0);
        end

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
